// File: rtl/multi_set_replacement_unit_if.sv
// multi_set_replacement_unit_if: controller <-> replacement engine bus (hits, victim requests, victims).
// Invalidate signals exist only when REPLACEMENT_INVALIDATE_EN is defined.
interface multi_set_replacement_unit_if #(
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int COUNTER_WIDTH = $clog2(NUMBER_OF_CACHE_LINES),
    parameter int NUMBER_OF_SETS = 8,
    parameter int SET_WIDTH = (NUMBER_OF_SETS > 1) ? $clog2(NUMBER_OF_SETS) : 1
);
    logic                     mode;
    logic                     access_valid;
    logic [SET_WIDTH-1:0]     access_set;
    logic [COUNTER_WIDTH-1:0] access_line;
    logic                     replace_request;
    logic [SET_WIDTH-1:0]     replace_set;
    logic                     replace_valid;
    logic [COUNTER_WIDTH-1:0] replace_line;
`ifdef REPLACEMENT_INVALIDATE_EN
    logic                     invalidate_valid;
    logic [SET_WIDTH-1:0]     invalidate_set;
    logic [COUNTER_WIDTH-1:0] invalidate_line;
`endif

    modport master (
        output mode, access_valid, access_set, access_line, replace_request, replace_set,
`ifdef REPLACEMENT_INVALIDATE_EN
        output invalidate_valid, invalidate_set, invalidate_line,
`endif
        input  replace_valid, replace_line
    );

    modport slave (
        input  mode, access_valid, access_set, access_line, replace_request, replace_set,
`ifdef REPLACEMENT_INVALIDATE_EN
        input  invalidate_valid, invalidate_set, invalidate_line,
`endif
        output replace_valid, replace_line
    );
endinterface

// File: rtl/multi_set_replacement_unit.sv
// multi_set_replacement_unit: per-set age-counter LRU/FIFO victim selection with a registered victim pulse.
// Optional REPLACEMENT_INVALIDATE_EN adds invalidate-driven demotion (invalidated line becomes next victim).
module multi_set_replacement_unit #(
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int COUNTER_WIDTH = $clog2(NUMBER_OF_CACHE_LINES),
    parameter int NUMBER_OF_SETS = 8,
    parameter int SET_WIDTH = (NUMBER_OF_SETS > 1) ? $clog2(NUMBER_OF_SETS) : 1
) (
    input logic clock,
    input logic reset,
    multi_set_replacement_unit_if.slave rif
);
    localparam int N = NUMBER_OF_CACHE_LINES;
    typedef logic [COUNTER_WIDTH-1:0] age_t;
    localparam age_t OLDEST = age_t'(N - 1);

    logic [1:0] reset_sync_q;
    logic       rst_int_n;
    age_t       age_q [NUMBER_OF_SETS][N];
    age_t       age_d [NUMBER_OF_SETS][N];
    age_t       target [NUMBER_OF_SETS];
    logic [NUMBER_OF_SETS-1:0] promote, demote, rep_hit, inv_hit, acc_hit;
    age_t       victim;
    age_t       replace_line_q, replace_line_d;
    logic       replace_valid_q, replace_valid_d;

    // Assertion is immediate; release is retimed to the clock to avoid recovery hazards.
    always_ff @(posedge clock or negedge reset)
        if (!reset) reset_sync_q <= 2'b00;
        else        reset_sync_q <= {reset_sync_q[0], 1'b1};

    assign rst_int_n = reset_sync_q[1];

    always_comb begin
        victim = '0;
        for (int i = 0; i < N; i++)
            if (age_q[rif.replace_set][i] == OLDEST) victim = age_t'(i);
    end

    // One operation per set: replace beats invalidate beats access.
    always_comb begin
        rep_hit = '0;
        inv_hit = '0;
        acc_hit = '0;
        promote = '0;
        demote  = '0;
        for (int s = 0; s < NUMBER_OF_SETS; s++) begin
            rep_hit[s] = rif.replace_request && rif.replace_set == SET_WIDTH'(s);
`ifdef REPLACEMENT_INVALIDATE_EN
            inv_hit[s] = rif.invalidate_valid && rif.invalidate_set == SET_WIDTH'(s);
`endif
            acc_hit[s] = rif.access_valid && !rif.mode && rif.access_set == SET_WIDTH'(s);
            promote[s] = rep_hit[s] || (!inv_hit[s] && acc_hit[s]);
            demote[s]  = !rep_hit[s] && inv_hit[s];
`ifdef REPLACEMENT_INVALIDATE_EN
            target[s]  = rep_hit[s] ? victim : inv_hit[s] ? rif.invalidate_line : rif.access_line;
`else
            target[s]  = rep_hit[s] ? victim : rif.access_line;
`endif
        end
    end

    always_comb begin
        for (int s = 0; s < NUMBER_OF_SETS; s++)
            for (int j = 0; j < N; j++) begin
                age_d[s][j] = age_q[s][j];
                if (promote[s])
                    age_d[s][j] = (j == int'(target[s])) ? '0 :
                                  (age_q[s][j] < age_q[s][target[s]]) ? age_q[s][j] + 1'b1 : age_q[s][j];
                else if (demote[s])
                    age_d[s][j] = (j == int'(target[s])) ? OLDEST :
                                  (age_q[s][j] > age_q[s][target[s]]) ? age_q[s][j] - 1'b1 : age_q[s][j];
            end
        replace_valid_d = rif.replace_request;
        replace_line_d  = rif.replace_request ? victim : replace_line_q;
    end

    always_ff @(posedge clock or negedge rst_int_n)
        if (!rst_int_n) begin
            for (int s = 0; s < NUMBER_OF_SETS; s++)
                for (int i = 0; i < N; i++)
                    age_q[s][i] <= age_t'(N - 1 - i);
            replace_valid_q <= 1'b0;
            replace_line_q  <= '0;
        end else begin
            age_q           <= age_d;
            replace_valid_q <= replace_valid_d;
            replace_line_q  <= replace_line_d;
        end

    assign rif.replace_valid = replace_valid_q;
    assign rif.replace_line  = replace_line_q;
endmodule
